// File: rtl/adder_error_monitor.sv
// Streaming error-metric engine for approximate adders: compares in_s against the exact a+b
// and accumulates error count, saturating |error| sum and max |error|. ADDER_ERROR_MONITOR_SQ_EN adds sq_err_sum.
module adder_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 20,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH:0]     in_s,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [ACC_W-1:0]   abs_err_sum,
    output logic [WIDTH:0]     max_abs_err
`ifdef ADDER_ERROR_MONITOR_SQ_EN
    ,
    output logic [ACC_W+WIDTH-1:0] sq_err_sum
`endif
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // RUN   | accepting samples until the latched count is reached
    // DRAIN | no more transfers; waiting for the S1 stage to retire
    // DONE  | results final, held until the next start
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SW     = WIDTH + 1;
    localparam int ACC1_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   sample_count_q, sample_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [ACC_W-1:0]   abs_err_sum_q, abs_err_sum_d;
    logic [SW-1:0]      max_abs_err_q, max_abs_err_d;
    logic               s1_valid_q, s1_valid_d;
    logic [SW-1:0]      s1_exact_q, s1_exact_d;
    logic [SW-1:0]      s1_sum_q, s1_sum_d;

    logic               start_ok;
    logic               xfer;
    logic               ready;
    logic               last_xfer;
    logic [SW-1:0]      diff;
    logic [ACC1_W-1:0]  abs_sum_ext;

`ifdef ADDER_ERROR_MONITOR_SQ_EN
    localparam int SQ_W  = ACC_W + WIDTH;
    localparam int SQ1_W = SQ_W + 1;
    logic [SQ_W-1:0]    sq_err_sum_q, sq_err_sum_d;
    logic [2*SW-1:0]    sq_prod;
    logic [SQ1_W-1:0]   sq_sum_ext;
`endif

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        abs_err_sum_d  = abs_err_sum_q;
        max_abs_err_d  = max_abs_err_q;
        s1_valid_d     = 1'b0;
        s1_exact_d     = s1_exact_q;
        s1_sum_d       = s1_sum_q;

        start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        ready     = (state_q == ST_RUN) && (sample_count_q < target_q);
        xfer      = in_valid && ready;
        last_xfer = xfer && ((sample_count_q + CNT_ONE) == target_q);

        // S1: exact reference sum registered alongside the approximate one
        if (xfer) begin
            s1_valid_d     = 1'b1;
            s1_exact_d     = {1'b0, in_a} + {1'b0, in_b};
            s1_sum_d       = in_s;
            sample_count_d = sample_count_q + CNT_ONE;
        end

        // S2: absolute difference and statistics update
        if (s1_sum_q >= s1_exact_q) begin
            diff = s1_sum_q - s1_exact_q;
        end else begin
            diff = s1_exact_q - s1_sum_q;
        end
        abs_sum_ext = {1'b0, abs_err_sum_q} + ACC1_W'(diff);

        if (s1_valid_q) begin
            if (diff != '0) begin
                err_count_d = err_count_q + CNT_ONE;
            end
            abs_err_sum_d = abs_sum_ext[ACC_W] ? {ACC_W{1'b1}} : abs_sum_ext[ACC_W-1:0];
            if (diff > max_abs_err_q) begin
                max_abs_err_d = diff;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!ready || last_xfer) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Start is only honoured when the pipeline is empty, so clearing here loses nothing
        if (start_ok) begin
            target_d       = num_samples;
            sample_count_d = '0;
            err_count_d    = '0;
            abs_err_sum_d  = '0;
            max_abs_err_d  = '0;
        end
    end

`ifdef ADDER_ERROR_MONITOR_SQ_EN
    always_comb begin
        sq_err_sum_d = sq_err_sum_q;
        sq_prod      = {{SW{1'b0}}, diff} * {{SW{1'b0}}, diff};
        sq_sum_ext   = {1'b0, sq_err_sum_q} + SQ1_W'(sq_prod);
        if (start_ok) begin
            sq_err_sum_d = '0;
        end else if (s1_valid_q) begin
            sq_err_sum_d = sq_sum_ext[SQ_W] ? {SQ_W{1'b1}} : sq_sum_ext[SQ_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_err_sum_q <= '0;
        end else begin
            sq_err_sum_q <= sq_err_sum_d;
        end
    end

    assign sq_err_sum = sq_err_sum_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            target_q       <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            abs_err_sum_q  <= '0;
            max_abs_err_q  <= '0;
            s1_valid_q     <= 1'b0;
            s1_exact_q     <= '0;
            s1_sum_q       <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            abs_err_sum_q  <= abs_err_sum_d;
            max_abs_err_q  <= max_abs_err_d;
            s1_valid_q     <= s1_valid_d;
            s1_exact_q     <= s1_exact_d;
            s1_sum_q       <= s1_sum_d;
        end
    end

    assign in_ready     = ready;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign abs_err_sum  = abs_err_sum_q;
    assign max_abs_err  = max_abs_err_q;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Randomized bench for adder_error_monitor; totals are checked against a plain-arithmetic model.
// Honours ADDER_ERROR_MONITOR_SQ_EN for the squared-error output.
module tb_adder_error_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 20;
    localparam int ACC_W = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_samples = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic [WIDTH:0]     in_s = '0;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   sample_count;
    logic [CNT_W-1:0]   err_count;
    logic [ACC_W-1:0]   abs_err_sum;
    logic [WIDTH:0]     max_abs_err;
`ifdef ADDER_ERROR_MONITOR_SQ_EN
    logic [ACC_W+WIDTH-1:0] sq_err_sum;
`endif

    adder_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_s         (in_s),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .abs_err_sum  (abs_err_sum),
        .max_abs_err  (max_abs_err)
`ifdef ADDER_ERROR_MONITOR_SQ_EN
        ,
        .sq_err_sum   (sq_err_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] qa [1000];
    logic [WIDTH-1:0] qb [1000];
    logic [WIDTH:0]   qs [1000];

    longint m_cnt, m_err, m_abs, m_max, m_sq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_abs = 0; m_max = 0; m_sq = 0;
    endtask

    task automatic model_add(input int idx);
        longint d;
        d = longint'(qs[idx]) - (longint'(qa[idx]) + longint'(qb[idx]));
        if (d < 0) d = -d;
        m_cnt++;
        if (d != 0) m_err++;
        m_abs += d;
        if (d > m_max) m_max = d;
        m_sq += d * d;
    endtask

    task automatic fill(input int n, input int err_pct);
        for (int i = 0; i < n; i++) begin
            qa[i] = WIDTH'($urandom_range(0, 65535));
            qb[i] = WIDTH'($urandom_range(0, 65535));
            if (int'($urandom_range(0, 99)) < err_pct) begin
                qs[i] = (WIDTH+1)'($urandom_range(0, 131071));
            end else begin
                qs[i] = {1'b0, qa[i]} + {1'b0, qb[i]};
            end
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num_samples = CNT_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        model_clear();
    endtask

    // Streams qa/qb/qs[0..stop_at-1]; returns right after the edge of the last transfer.
    task automatic stream(input int duty, input int stop_at, input bit poke_start);
        int  sent = 0;
        int  cyc  = 0;
        bit  pend = 1'b0;
        bit  xfer;
        while (sent < stop_at && cyc < 20 * stop_at + 100) begin
            @(negedge clk);
            cyc++;
            if (!pend && int'($urandom_range(0, 99)) < duty) pend = 1'b1;
            if (pend) begin
                in_valid = 1'b1;
                in_a = qa[sent]; in_b = qb[sent]; in_s = qs[sent];
            end else begin
                in_valid = 1'b0;
                in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_s = (WIDTH+1)'($urandom);
            end
            start = poke_start && ($urandom_range(0, 7) == 0);
            if (poke_start) num_samples = CNT_W'($urandom_range(1, 5));
            xfer = in_valid && in_ready;
            @(posedge clk);
            if (xfer) begin
                model_add(sent);
                sent++;
                pend = 1'b0;
            end
        end
        chk("stream_sent", 64'(sent), 64'(stop_at));
    endtask

    task automatic check_done_timing(input string tag);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        chk({tag, "_ready_after_last"}, 64'(in_ready), 64'd0);
        chk({tag, "_done_plus1"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, "_done_plus2_pre"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, "_done_plus2"}, 64'(done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_sample_count"}, 64'(sample_count), 64'(m_cnt));
        chk({tag, "_err_count"}, 64'(err_count), 64'(m_err));
        chk({tag, "_abs_err_sum"}, 64'(abs_err_sum), 64'(m_abs));
        chk({tag, "_max_abs_err"}, 64'(max_abs_err), 64'(m_max));
`ifdef ADDER_ERROR_MONITOR_SQ_EN
        chk({tag, "_sq_err_sum"}, 64'(sq_err_sum), 64'(m_sq));
`endif
    endtask

    initial begin
        bit saw_ready;
        bit saw_done;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        model_clear();
        check_results("rst");
        @(negedge clk);
        rst = 1'b0;

        // exact adder, back-to-back
        fill(1000, 0);
        do_start(1000);
        stream(100, 1000, 1'b0);
        check_done_timing("exact");
        check_results("exact");
        chk("exact_err_zero", 64'(err_count), 64'd0);

        // directed samples including the carry-out boundary
        qa[0] = 16'd5;    qb[0] = 16'd3; qs[0] = 17'd9;
        qa[1] = 16'hFFFF; qb[1] = 16'd1; qs[1] = 17'h0FFFF;
        qa[2] = 16'd2;    qb[2] = 16'd2; qs[2] = 17'd4;
        qa[3] = 16'hFFFF; qb[3] = 16'd1; qs[3] = 17'h00000;
        do_start(4);
        stream(100, 4, 1'b0);
        check_done_timing("dir");
        chk("dir_err_count", 64'(err_count), 64'd3);
        chk("dir_abs_err_sum", 64'(abs_err_sum), 64'h10002);
        chk("dir_max_abs_err", 64'(max_abs_err), 64'h10000);
`ifdef ADDER_ERROR_MONITOR_SQ_EN
        chk("dir_sq_err_sum", 64'(sq_err_sum), 64'h1_0000_0002);
`endif

        // zero-length run
        do_start(0);
        saw_ready = 1'b0;
        saw_done  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (in_ready) saw_ready = 1'b1;
            if (done) saw_done = 1'b1;
        end
        chk("zero_ready_seen", 64'(saw_ready), 64'd0);
        chk("zero_done_by_3", 64'(saw_done), 64'd1);
        check_results("zero");

        // bubbles with random errors
        fill(500, 40);
        do_start(500);
        stream(50, 500, 1'b0);
        check_done_timing("bub");
        check_results("bub");

        // reset in the middle of a run
        fill(500, 40);
        do_start(500);
        stream(60, 100, 1'b0);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_sample_count", 64'(sample_count), 64'd0);
        chk("mid_rst_abs_err_sum", 64'(abs_err_sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        fill(10, 50);
        do_start(10);
        stream(70, 10, 1'b0);
        check_done_timing("post_rst");
        check_results("post_rst");

        // start pulses while busy must be ignored
        fill(200, 30);
        do_start(200);
        stream(80, 200, 1'b1);
        check_done_timing("poke");
        check_results("poke");

        // restart from DONE clears everything on the next edge
        do_start(50);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        check_results("restart_clear");
        fill(50, 50);
        stream(50, 50, 1'b0);
        check_done_timing("restart");
        check_results("restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
